note_pattern_gen: RTL and testbench
===================================

NOTE_PATTERN_GEN -- requirements
Module: note_pattern_gen

Interface
REQ-001 Parameter DATA_W, default 8, note code width.
REQ-002 Parameter NOTE_LO, default 60, lowest note code.
REQ-003 Parameter NOTE_HI, default 76, highest note code.
REQ-004 Parameter NOTE_STEP, default 4, increment per beat; legal when 1 <= NOTE_STEP <= NOTE_HI-NOTE_LO.
REQ-005 Port clk, input, 1, sole clock; all logic on rising edge.
REQ-006 Port reset, input, 1, synchronous active-high reset.
REQ-007 Port start, input, 1, single-cycle pulse arming the generator.
REQ-008 Port stop, input, 1, single-cycle pulse disarming the generator.
REQ-009 Port mode, input, 2, pattern: 0 up-wrap, 1 down-wrap, 2 ping-pong, 3 hold.
REQ-010 Port data_ready, input, 1, consumer accepts data this cycle.
REQ-011 Port data_valid, output, 1, data holds a valid note.
REQ-012 Port data, output, DATA_W, current note code.
REQ-013 Port wrap, output, 1, one-cycle pulse on the beat that wraps or reverses.
REQ-014 Port active, output, 1, generator armed.

Function
REQ-015 Beat accepted = data_valid & data_ready; data advances only on an accepted beat, otherwise holds.
REQ-016 start while idle: active=1 next cycle, data loaded with NOTE_HI if mode==1, else NOTE_LO; data_valid=1 the same cycle as active; ping-pong direction set to up.
REQ-017 start while active: reload per REQ-016; any pending beat is discarded.
REQ-018 stop: active=0, data_valid=0 next cycle; data keeps its last value; stop wins over a simultaneous start.
REQ-019 data_valid = active; no bubble between consecutive accepted beats.
REQ-020 Up-wrap: next = data+NOTE_STEP computed at DATA_W+1 bits; if next > NOTE_HI then data <= NOTE_LO and wrap=1.
REQ-021 Down-wrap: if data < NOTE_LO+NOTE_STEP then data <= NOTE_HI and wrap=1, else data <= data-NOTE_STEP.
REQ-022 Ping-pong up: if data+NOTE_STEP > NOTE_HI, direction flips to down, data <= data-NOTE_STEP, wrap=1; otherwise data increments.
REQ-023 Ping-pong down: if data < NOTE_LO+NOTE_STEP, direction flips to up, data <= data+NOTE_STEP, wrap=1; otherwise data decrements.
REQ-024 Hold: data unchanged on accepted beats; wrap never asserted.
REQ-025 mode is sampled on every accepted beat; a change takes effect on the next advance without reload; direction is retained.
REQ-026 An out-of-range data value (< NOTE_LO or > NOTE_HI) is replaced by NOTE_LO on the next accepted beat, with wrap=1.
REQ-027 wrap is registered and high exactly one cycle after the triggering accepted beat.

Reset
REQ-028 On reset: active=0, data_valid=0, data=NOTE_LO, wrap=0, direction=up, loop counter=0; reset overrides start/stop.

Configuration
REQ-029 Macro NOTE_GEN_LOOP_LIMIT_EN defined: parameter LOOP_MAX (default 4) and output loop_cnt (8 bits) are present.
REQ-030 With the macro, loop_cnt increments on each wrap pulse (saturating at 255) and clears on start.
REQ-031 With the macro, when loop_cnt reaches LOOP_MAX the generator performs an internal stop per REQ-018.
REQ-032 Without the macro: no loop_cnt port; the generator runs until stop or reset.

Structure
REQ-033 Package note_gen_pkg holds the mode enum (MODE_UP, MODE_DOWN, MODE_PINGPONG, MODE_HOLD) and the default NOTE_LO/NOTE_HI/NOTE_STEP constants.
REQ-034 Optional sub-module note_step_calc: combinational next-note and wrap computation from data, mode and direction.

Verification
REQ-035 Defaults, mode 0, start, ready=1 -> data 60,64,68,72,76,60,...; wrap one cycle after the 76 beat.
REQ-036 mode 1, start -> 76,72,68,64,60,76; wrap follows the 60 beat.
REQ-037 mode 2 -> 60,64,68,72,76,72,68,64,60,64; wrap after 76 and after 60.
REQ-038 NOTE_STEP=5 mode 0 -> 60,65,70,75,60; ready low 3 cycles at 70 -> 70 held and valid stays 1.
REQ-039 start and stop in the same cycle while idle -> active stays 0; stop mid-run at 68 -> valid=0, data=68.
REQ-040 NOTE_GEN_LOOP_LIMIT_EN, LOOP_MAX=2, mode 0 -> after the second wrap, active=0 and loop_cnt=2.

Source files
------------

// File: rtl/note_gen_pkg.sv
// Shared pattern-mode encoding and default note range for the note pattern generator.
package note_gen_pkg;

  typedef enum logic [1:0] {
    MODE_UP       = 2'd0,
    MODE_DOWN     = 2'd1,
    MODE_PINGPONG = 2'd2,
    MODE_HOLD     = 2'd3
  } mode_e;

  localparam int NOTE_LO_DEF   = 60;
  localparam int NOTE_HI_DEF   = 76;
  localparam int NOTE_STEP_DEF = 4;

endpackage

// File: rtl/note_step_calc.sv
// Combinational next-note, next-direction and wrap flag from the current note, mode and direction.
module note_step_calc
  import note_gen_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NOTE_LO   = NOTE_LO_DEF,
  parameter int NOTE_HI   = NOTE_HI_DEF,
  parameter int NOTE_STEP = NOTE_STEP_DEF
) (
  input  logic [DATA_W-1:0] data,
  input  logic [1:0]        mode,
  input  logic              dir_down,
  output logic [DATA_W-1:0] next_data,
  output logic              next_dir_down,
  output logic              wrap
);

  localparam logic [DATA_W:0] STEP_X  = (DATA_W+1)'(NOTE_STEP);
  localparam logic [DATA_W:0] LO_X    = (DATA_W+1)'(NOTE_LO);
  localparam logic [DATA_W:0] HI_X    = (DATA_W+1)'(NOTE_HI);
  localparam logic [DATA_W:0] LO_PLUS = LO_X + STEP_X;

  logic [DATA_W:0]   data_x;
  logic [DATA_W:0]   up_sum;
  logic [DATA_W-1:0] dn_diff;
  logic              up_over;
  logic              dn_under;
  logic              out_of_range;

  // Sum is one bit wider so a step past the top of the code space is still seen as "over".
  assign data_x       = {1'b0, data};
  assign up_sum       = data_x + STEP_X;
  assign dn_diff      = data - STEP_X[DATA_W-1:0];
  assign up_over      = up_sum > HI_X;
  assign dn_under     = data_x < LO_PLUS;
  assign out_of_range = (data_x < LO_X) || (data_x > HI_X);

  always_comb begin
    next_data     = data;
    next_dir_down = dir_down;
    wrap          = 1'b0;
    if (out_of_range) begin
      next_data = LO_X[DATA_W-1:0];
      wrap      = 1'b1;
    end else begin
      case (mode_e'(mode))
        MODE_UP: begin
          if (up_over) begin
            next_data = LO_X[DATA_W-1:0];
            wrap      = 1'b1;
          end else begin
            next_data = up_sum[DATA_W-1:0];
          end
        end
        MODE_DOWN: begin
          if (dn_under) begin
            next_data = HI_X[DATA_W-1:0];
            wrap      = 1'b1;
          end else begin
            next_data = dn_diff;
          end
        end
        MODE_PINGPONG: begin
          if (!dir_down) begin
            if (up_over) begin
              next_dir_down = 1'b1;
              next_data     = dn_diff;
              wrap          = 1'b1;
            end else begin
              next_data = up_sum[DATA_W-1:0];
            end
          end else begin
            if (dn_under) begin
              next_dir_down = 1'b0;
              next_data     = up_sum[DATA_W-1:0];
              wrap          = 1'b1;
            end else begin
              next_data = dn_diff;
            end
          end
        end
        default: begin
          next_data = data;
        end
      endcase
    end
  end

endmodule

// File: rtl/note_pattern_gen.sv
// Note pattern generator: up/down/ping-pong/hold note sequences advanced on accepted valid/ready beats.
// Optional loop limit (loop_cnt port, LOOP_MAX) enabled by defining NOTE_GEN_LOOP_LIMIT_EN.
module note_pattern_gen
  import note_gen_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int NOTE_LO   = NOTE_LO_DEF,
  parameter int NOTE_HI   = NOTE_HI_DEF,
  parameter int NOTE_STEP = NOTE_STEP_DEF
`ifdef NOTE_GEN_LOOP_LIMIT_EN
  ,
  parameter int LOOP_MAX  = 4
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic              data_ready,
  output logic              data_valid,
  output logic [DATA_W-1:0] data,
  output logic              wrap,
  output logic              active
`ifdef NOTE_GEN_LOOP_LIMIT_EN
  ,
  output logic [7:0]        loop_cnt
`endif
);

  localparam logic [DATA_W-1:0] LO_D = DATA_W'(NOTE_LO);
  localparam logic [DATA_W-1:0] HI_D = DATA_W'(NOTE_HI);

  logic              dir_down;
  logic              beat;
  logic              stop_all;
  logic [DATA_W-1:0] calc_data;
  logic              calc_dir_down;
  logic              calc_wrap;

  assign data_valid = active;
  assign beat       = active & data_ready;

`ifdef NOTE_GEN_LOOP_LIMIT_EN
  // Limit stop is qualified by active so a fresh start can still clear the counter.
  assign stop_all = stop | (active & (loop_cnt >= 8'(LOOP_MAX)));
`else
  assign stop_all = stop;
`endif

  note_step_calc #(
    .DATA_W   (DATA_W),
    .NOTE_LO  (NOTE_LO),
    .NOTE_HI  (NOTE_HI),
    .NOTE_STEP(NOTE_STEP)
  ) u_calc (
    .data         (data),
    .mode         (mode),
    .dir_down     (dir_down),
    .next_data    (calc_data),
    .next_dir_down(calc_dir_down),
    .wrap         (calc_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      active   <= 1'b0;
      data     <= LO_D;
      wrap     <= 1'b0;
      dir_down <= 1'b0;
`ifdef NOTE_GEN_LOOP_LIMIT_EN
      loop_cnt <= 8'd0;
`endif
    end else if (stop_all) begin
      active <= 1'b0;
      wrap   <= 1'b0;
    end else if (start) begin
      active   <= 1'b1;
      data     <= (mode_e'(mode) == MODE_DOWN) ? HI_D : LO_D;
      dir_down <= 1'b0;
      wrap     <= 1'b0;
`ifdef NOTE_GEN_LOOP_LIMIT_EN
      loop_cnt <= 8'd0;
`endif
    end else if (beat) begin
      data     <= calc_data;
      dir_down <= calc_dir_down;
      wrap     <= calc_wrap;
`ifdef NOTE_GEN_LOOP_LIMIT_EN
      if (calc_wrap && loop_cnt != 8'hFF) loop_cnt <= loop_cnt + 8'd1;
`endif
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_note_pattern_gen.sv
// Directed bench for note_pattern_gen: default-step instance plus a NOTE_STEP=5 instance on shared inputs.
module tb_note_pattern_gen;

  logic       clk = 1'b0;
  logic       reset, start, stop, data_ready;
  logic [1:0] mode;

  logic       valid_a, wrap_a, active_a;
  logic [7:0] data_a;
  logic       valid_b, wrap_b, active_b;
  logic [7:0] data_b;
`ifdef NOTE_GEN_LOOP_LIMIT_EN
  logic [7:0] loop_cnt_a, loop_cnt_b;
`endif

  int checks = 0;
  int errors = 0;

  int up_d[7]   = '{60, 64, 68, 72, 76, 60, 64};
  int up_w[7]   = '{0, 0, 0, 0, 0, 1, 0};
  int dn_d[6]   = '{76, 72, 68, 64, 60, 76};
  int dn_w[6]   = '{0, 0, 0, 0, 0, 1};
  int pp_d[10]  = '{60, 64, 68, 72, 76, 72, 68, 64, 60, 64};
  int pp_w[10]  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1};

  always #5 clk = ~clk;

  note_pattern_gen
`ifdef NOTE_GEN_LOOP_LIMIT_EN
    #(.LOOP_MAX(255))
`endif
  u_dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .data_ready(data_ready), .data_valid(valid_a), .data(data_a),
    .wrap(wrap_a), .active(active_a)
`ifdef NOTE_GEN_LOOP_LIMIT_EN
    , .loop_cnt(loop_cnt_a)
`endif
  );

  note_pattern_gen #(
    .NOTE_STEP(5)
`ifdef NOTE_GEN_LOOP_LIMIT_EN
    , .LOOP_MAX(255)
`endif
  ) u_dut5 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
    .data_ready(data_ready), .data_valid(valid_b), .data(data_b),
    .wrap(wrap_b), .active(active_b)
`ifdef NOTE_GEN_LOOP_LIMIT_EN
    , .loop_cnt(loop_cnt_b)
`endif
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [1:0] m);
    mode  = m;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; stop = 1'b0; data_ready = 1'b1; mode = 2'd0;
    tick(); tick();
    chk("rst_active", active_a, 0);
    chk("rst_valid", valid_a, 0);
    chk("rst_data", data_a, 60);
    chk("rst_wrap", wrap_a, 0);
    // Reset must dominate a simultaneous start.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("rst_over_start", active_a, 0);
    reset = 1'b0;
    tick();

    pulse_start(2'd0);
    chk("up_active", active_a, 1);
    chk("up_valid", valid_a, 1);
    for (int i = 0; i < 7; i++) begin
      chk($sformatf("up_data%0d", i), data_a, up_d[i]);
      chk($sformatf("up_wrap%0d", i), wrap_a, up_w[i]);
      tick();
    end

    // Restart while running, now in down mode.
    pulse_start(2'd1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("dn_data%0d", i), data_a, dn_d[i]);
      chk($sformatf("dn_wrap%0d", i), wrap_a, dn_w[i]);
      tick();
    end

    pulse_start(2'd2);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("pp_data%0d", i), data_a, pp_d[i]);
      chk($sformatf("pp_wrap%0d", i), wrap_a, pp_w[i]);
      tick();
    end

    // Stop mid-run at 68.
    pulse_start(2'd0);
    tick(); tick();
    chk("stop_pre_data", data_a, 68);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_valid", valid_a, 0);
    chk("stop_active", active_a, 0);
    chk("stop_data", data_a, 68);
    tick(); tick();
    chk("stop_data_held", data_a, 68);

    // Start and stop together while idle: stop wins.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_active", active_a, 0);
    chk("ss_valid", valid_a, 0);

    // Step-5 instance with a three-cycle stall at 70.
    pulse_start(2'd0);
    chk("s5_d0", data_b, 60);
    tick();
    chk("s5_d1", data_b, 65);
    tick();
    chk("s5_d2", data_b, 70);
    data_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("s5_stall_data%0d", i), data_b, 70);
      chk($sformatf("s5_stall_valid%0d", i), valid_b, 1);
      chk($sformatf("s5_stall_wrap%0d", i), wrap_b, 0);
    end
    data_ready = 1'b1;
    tick();
    chk("s5_d3", data_b, 75);
    chk("s5_w3", wrap_b, 0);
    tick();
    chk("s5_d4", data_b, 60);
    chk("s5_w4", wrap_b, 1);

    // Switch to hold mid-run without reload: note frozen, no wrap.
    mode = 2'd3;
    tick();
    chk("hold_data", data_b, 60);
    chk("hold_wrap", wrap_b, 0);
    tick();
    chk("hold_data2", data_b, 60);
    chk("hold_active", active_b, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
